// File: rtl/mips_pkg.sv
// Types and defaults shared by the instruction-fetch / data-memory port arbiter.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_DM = 1'b1
    } arb_port_t;

    localparam int MEM_LAT_DEF = 2;

    // Counter width able to hold the latency value itself.
    function automatic int lat_cnt_w(input int lat);
        return (lat < 2) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/mem_lat_timer.sv
// Memory read-latency timer: loaded in ISSUE, counts down in WAIT,
// flags the last WAIT cycle so the FSM enters RESP as read data becomes valid.
module mem_lat_timer
    import mips_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic run_i,
    output logic done_o
);

    localparam int            CW    = lat_cnt_w(MEM_LAT);
    localparam logic [CW-1:0] LAT_V = CW'(MEM_LAT);
    localparam logic [CW-1:0] ONE   = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LAT_V;
        end else if (run_i && cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = run_i && (cnt_q == ONE);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between IF and DM with alternating priority on conflict.
// Define ARB_PERF_CNT_EN to build the saturating conflict counter.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       conflict_cnt
);

    arb_state_t        state_q, state_d;
    arb_port_t         last_grant_q, last_grant_d;
    arb_port_t         grant;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic              dm_ack_q, dm_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              timer_load, timer_run, timer_done;
    logic              conflict_inc;

    mem_lat_timer #(
        .MEM_LAT (MEM_LAT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load_i (timer_load),
        .run_i  (timer_run),
        .done_o (timer_done)
    );

    // Single requester wins outright; on conflict the port not served last wins.
    always_comb begin
        grant = PORT_IF;
        if (if_req && dm_req) begin
            grant = (last_grant_q == PORT_IF) ? PORT_DM : PORT_IF;
        end else if (dm_req) begin
            grant = PORT_DM;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_en_d     = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_ack_d     = 1'b0;
        dm_ack_d     = 1'b0;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        timer_load   = 1'b0;
        timer_run    = 1'b0;
        conflict_inc = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    state_d      = ISSUE;
                    last_grant_d = grant;
                    mem_en_d     = 1'b1;
                    conflict_inc = if_req && dm_req;
                    if (grant == PORT_DM) begin
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                    end else begin
                        mem_we_d   = 1'b0;
                        mem_addr_d = if_addr;
                    end
                end
            end
            ISSUE: begin
                timer_load = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                timer_run = 1'b1;
                // Read data is valid in this last WAIT cycle; capture on the RESP entry edge.
                if (timer_done) begin
                    state_d = RESP;
                    if (last_grant_q == PORT_DM) begin
                        dm_ack_d = 1'b1;
                        if (!mem_we_q) begin
                            dm_rdata_d = mem_rdata;
                        end
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_IF;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_ack_q     <= if_ack_d;
            dm_ack_q     <= dm_ack_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (conflict_inc && conflict_cnt_q != 16'hFFFF) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign conflict_cnt = conflict_cnt_q;
`else
    logic unused_conflict_inc;
    assign unused_conflict_inc = conflict_inc;
    assign conflict_cnt        = 16'h0000;
`endif

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run against a transaction-level model of the arbitration and memory.
module tb_mem_port_arbiter;
    localparam int LAT = 2;
`ifdef ARB_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
    logic        if_ack, dm_ack, mem_en, mem_we;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic [15:0] conflict_cnt;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
    );

    // Behavioural single-port memory answering the DUT LAT cycles after mem_en.
    typedef struct { int due; logic [31:0] d; } rd_t;
    rd_t         rdq[$];
    logic [31:0] dev_mem[logic [31:0]];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic tick();
        rd_t r;
        @(posedge clk);
        #1;
        cyc++;
        if (mem_en === 1'b1) begin
            if (mem_we) dev_mem[mem_addr] = mem_wdata;
            else begin
                r.due = cyc + LAT;
                r.d   = dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : dflt(mem_addr);
                rdq.push_back(r);
            end
        end
        while (rdq.size() > 0 && rdq[0].due < cyc) void'(rdq.pop_front());
        if (rdq.size() > 0 && rdq[0].due == cyc) begin
            r = rdq.pop_front();
            mem_rdata = r.d;
        end else begin
            mem_rdata = $urandom;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; if_req = 0; dm_req = 0; dm_we = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; if_req = 1; dm_req = 1; dm_we = 1;
        if_addr = $urandom; dm_addr = $urandom; dm_wdata = $urandom;
        repeat (3) begin
            tick();
            n_chk++;
            if ({if_ack, dm_ack, mem_en, mem_we} !== 4'b0) begin
                n_fail++; $display("FAIL rst_ctl got=%b exp=0000", {if_ack, dm_ack, mem_en, mem_we});
            end
        end
        n_chk++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
        n_chk++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
        n_chk++; if (if_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_if_rdata got=%h exp=0", if_rdata); end
        n_chk++; if (dm_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_dm_rdata got=%h exp=0", dm_rdata); end
        n_chk++; if (conflict_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_cnt got=%h exp=0", conflict_cnt); end
    endtask

    task automatic test_if_read();
        logic e;
        do_reset();
        dev_mem[32'h0040_0000] = 32'h2108_0004;
        if_req = 1; if_addr = 32'h0040_0000;
        for (int k = 1; k <= 6; k++) begin
            tick();
            e = (k == 1);
            n_chk++; if (mem_en !== e) begin n_fail++; $display("FAIL ifrd_mem_en k=%0d got=%b exp=%b", k, mem_en, e); end
            if (k == 1) begin
                n_chk++;
                if (mem_addr !== 32'h0040_0000 || mem_we !== 1'b0) begin
                    n_fail++; $display("FAIL ifrd_issue addr=%h we=%b exp addr=00400000 we=0", mem_addr, mem_we);
                end
            end
            e = (k == 4);
            n_chk++; if (if_ack !== e || dm_ack !== 1'b0) begin n_fail++; $display("FAIL ifrd_ack k=%0d if=%b dm=%b exp if=%b dm=0", k, if_ack, dm_ack, e); end
            if (k == 4) begin
                n_chk++; if (if_rdata !== 32'h2108_0004) begin n_fail++; $display("FAIL ifrd_data got=%h exp=21080004", if_rdata); end
                if_req = 0;
            end
        end
    endtask

    task automatic test_dm_write();
        logic e;
        do_reset();
        dm_req = 1; dm_we = 1; dm_addr = 32'h1001_0000; dm_wdata = 32'hDEAD_BEEF;
        for (int k = 1; k <= 6; k++) begin
            tick();
            e = (k == 1);
            n_chk++; if (mem_en !== e) begin n_fail++; $display("FAIL dmwr_mem_en k=%0d got=%b exp=%b", k, mem_en, e); end
            if (k == 1) begin
                n_chk++;
                if (mem_we !== 1'b1 || mem_addr !== 32'h1001_0000 || mem_wdata !== 32'hDEAD_BEEF) begin
                    n_fail++; $display("FAIL dmwr_issue we=%b addr=%h data=%h exp 1/10010000/deadbeef", mem_we, mem_addr, mem_wdata);
                end
            end
            e = (k == 4);
            n_chk++; if (dm_ack !== e || if_ack !== 1'b0) begin n_fail++; $display("FAIL dmwr_ack k=%0d dm=%b if=%b exp dm=%b if=0", k, dm_ack, if_ack, e); end
            if (k >= 4) begin
                n_chk++; if (dm_rdata !== 32'h0) begin n_fail++; $display("FAIL dmwr_rdata k=%0d got=%h exp=0", k, dm_rdata); end
            end
            if (k == 4) begin dm_req = 0; dm_we = 0; end
        end
    endtask

    task automatic test_conflict();
        logic e;
        do_reset();
        if_req = 1; if_addr = 32'h0040_0010;
        dm_req = 1; dm_we = 0; dm_addr = 32'h1000_0020;
        for (int k = 1; k <= 10; k++) begin
            tick();
            e = (k == 1 || k == 6);
            n_chk++; if (mem_en !== e) begin n_fail++; $display("FAIL conf_mem_en k=%0d got=%b exp=%b", k, mem_en, e); end
            if (k == 1) begin n_chk++; if (mem_addr !== 32'h1000_0020) begin n_fail++; $display("FAIL conf_first addr=%h exp=10000020", mem_addr); end end
            if (k == 6) begin n_chk++; if (mem_addr !== 32'h0040_0010) begin n_fail++; $display("FAIL conf_second addr=%h exp=00400010", mem_addr); end end
            e = (k == 4);
            n_chk++; if (dm_ack !== e) begin n_fail++; $display("FAIL conf_dm_ack k=%0d got=%b exp=%b", k, dm_ack, e); end
            e = (k == 9);
            n_chk++; if (if_ack !== e) begin n_fail++; $display("FAIL conf_if_ack k=%0d got=%b exp=%b", k, if_ack, e); end
            if (k == 4) begin
                n_chk++; if (dm_rdata !== dflt(32'h1000_0020)) begin n_fail++; $display("FAIL conf_dm_data got=%h exp=%h", dm_rdata, dflt(32'h1000_0020)); end
                dm_req = 0;
            end
            if (k == 9) begin
                n_chk++; if (if_rdata !== dflt(32'h0040_0010)) begin n_fail++; $display("FAIL conf_if_data got=%h exp=%h", if_rdata, dflt(32'h0040_0010)); end
                if_req = 0;
            end
        end
        n_chk++; if (conflict_cnt !== (PERF ? 16'd1 : 16'd0)) begin n_fail++; $display("FAIL conf_cnt got=%0d exp=%0d", conflict_cnt, PERF ? 1 : 0); end
    endtask

    task automatic test_fairness();
        logic        e, e_dm;
        int          j;
        logic [31:0] ea;
        do_reset();
        if_req = 1; if_addr = 32'h0050_0000;
        dm_req = 1; dm_we = 0; dm_addr = 32'h1100_0000;
        for (int k = 1; k <= 25; k++) begin
            tick();
            e = ((k - 1) % 5 == 0) && k <= 21;
            n_chk++; if (mem_en !== e) begin n_fail++; $display("FAIL fair_mem_en k=%0d got=%b exp=%b", k, mem_en, e); end
            if (e) begin
                j  = (k - 1) / 5;
                ea = (j % 2 == 0) ? 32'h1100_0000 + 32'(j / 2) * 4 : 32'h0050_0000 + 32'(j / 2) * 4;
                n_chk++; if (mem_addr !== ea) begin n_fail++; $display("FAIL fair_grant j=%0d addr=%h exp=%h", j, mem_addr, ea); end
            end
            j    = (k - 4) / 5;
            e    = (k >= 4) && ((k - 4) % 5 == 0);
            e_dm = e && (j % 2 == 0);
            n_chk++;
            if (dm_ack !== e_dm || if_ack !== (e && !e_dm)) begin
                n_fail++; $display("FAIL fair_ack k=%0d dm=%b if=%b exp dm=%b if=%b", k, dm_ack, if_ack, e_dm, e && !e_dm);
            end
            if (dm_ack === 1'b1) begin
                if (k == 24) dm_req = 0;
                else dm_addr = dm_addr + 4;
            end
            if (if_ack === 1'b1) begin
                if (k == 19) if_req = 0;
                else if_addr = if_addr + 4;
            end
        end
        n_chk++; if (conflict_cnt !== (PERF ? 16'd4 : 16'd0)) begin n_fail++; $display("FAIL fair_cnt got=%0d exp=%0d", conflict_cnt, PERF ? 4 : 0); end
    endtask

    task automatic test_reset_mid();
        logic e;
        do_reset();
        dm_req = 1; dm_we = 0; dm_addr = 32'h1000_0080;
        for (int k = 1; k <= 2; k++) begin
            tick();
            e = (k == 1);
            n_chk++; if (mem_en !== e) begin n_fail++; $display("FAIL rmid_mem_en k=%0d got=%b exp=%b", k, mem_en, e); end
        end
        reset = 1; dm_req = 0;
        tick();
        n_chk++;
        if ({if_ack, dm_ack, mem_en, mem_we} !== 4'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
            if_rdata !== 32'h0 || dm_rdata !== 32'h0 || conflict_cnt !== 16'h0) begin
            n_fail++; $display("FAIL rmid_zero ctl=%b addr=%h wd=%h ifd=%h dmd=%h cnt=%h exp all 0",
                               {if_ack, dm_ack, mem_en, mem_we}, mem_addr, mem_wdata, if_rdata, dm_rdata, conflict_cnt);
        end
        reset = 0; if_req = 1; if_addr = 32'h0040_0100;
        for (int k = 4; k <= 10; k++) begin
            tick();
            e = (k == 4);
            n_chk++; if (mem_en !== e) begin n_fail++; $display("FAIL rmid_new_en k=%0d got=%b exp=%b", k, mem_en, e); end
            if (k == 4) begin n_chk++; if (mem_addr !== 32'h0040_0100) begin n_fail++; $display("FAIL rmid_new_addr got=%h exp=00400100", mem_addr); end end
            e = (k == 7);
            n_chk++; if (if_ack !== e || dm_ack !== 1'b0) begin n_fail++; $display("FAIL rmid_ack k=%0d if=%b dm=%b exp if=%b dm=0", k, if_ack, dm_ack, e); end
            if (k == 7) if_req = 0;
        end
    endtask

    task automatic test_held_req();
        logic e;
        do_reset();
        dm_req = 1; dm_we = 0; dm_addr = 32'h1000_0040;
        for (int k = 1; k <= 10; k++) begin
            tick();
            e = (k == 1 || k == 6);
            n_chk++; if (mem_en !== e) begin n_fail++; $display("FAIL held_mem_en k=%0d got=%b exp=%b", k, mem_en, e); end
            e = (k == 4 || k == 9);
            n_chk++; if (dm_ack !== e) begin n_fail++; $display("FAIL held_dm_ack k=%0d got=%b exp=%b", k, dm_ack, e); end
            if (k == 6) dm_req = 0;
        end
    endtask

    // Transaction-level model: next arbitration cycle, expected issue/ack cycles, model memory.
    task automatic test_random();
        logic [31:0] mmem[logic [31:0]];
        logic        if_p, dm_p, d_we, exp_we, e, e_dm, last_dm, dm_win;
        logic [31:0] i_a, d_a, d_w, exp_a, exp_w, exp_rd, m_ifd, m_dmd;
        int          idle_at, exp_en_c, exp_ack_c, c;
        int          m_conf;
        do_reset();
        if_p = 0; dm_p = 0; last_dm = 0; m_ifd = '0; m_dmd = '0; m_conf = 0;
        i_a = '0; d_a = '0; d_w = '0; d_we = 0; exp_we = 0; exp_a = '0; exp_w = '0; exp_rd = '0; dm_win = 0;
        idle_at = cyc; exp_en_c = -10; exp_ack_c = -10;
        for (int i = 0; i < 3000; i++) begin
            c = cyc;
            if (i > 0) begin
                tick();
                c = cyc;
                e = (c == exp_en_c);
                n_chk++; if (mem_en !== e) begin n_fail++; $display("FAIL rnd_mem_en c=%0d got=%b exp=%b", c, mem_en, e); end
                if (e) begin
                    n_chk++;
                    if (mem_we !== exp_we || mem_addr !== exp_a || (exp_we && mem_wdata !== exp_w)) begin
                        n_fail++; $display("FAIL rnd_issue c=%0d we=%b addr=%h wd=%h exp %b/%h/%h", c, mem_we, mem_addr, mem_wdata, exp_we, exp_a, exp_w);
                    end
                end
                e    = (c == exp_ack_c);
                e_dm = e && dm_win;
                n_chk++;
                if (dm_ack !== e_dm || if_ack !== (e && !dm_win)) begin
                    n_fail++; $display("FAIL rnd_ack c=%0d dm=%b if=%b exp dm=%b if=%b", c, dm_ack, if_ack, e_dm, e && !dm_win);
                end
                if (e) begin
                    if (dm_win) begin dm_p = 0; if (!exp_we) m_dmd = exp_rd; end
                    else begin if_p = 0; m_ifd = exp_rd; end
                end
                n_chk++; if (if_rdata !== m_ifd) begin n_fail++; $display("FAIL rnd_if_rdata c=%0d got=%h exp=%h", c, if_rdata, m_ifd); end
                n_chk++; if (dm_rdata !== m_dmd) begin n_fail++; $display("FAIL rnd_dm_rdata c=%0d got=%h exp=%h", c, dm_rdata, m_dmd); end
                n_chk++;
                if (conflict_cnt !== (PERF ? 16'(m_conf) : 16'h0)) begin
                    n_fail++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, conflict_cnt, PERF ? m_conf : 0);
                end
            end
            if (!if_p && $urandom_range(0, 2) == 0) begin
                if_p = 1; i_a = 32'h2000_0000 | (32'($urandom_range(0, 15)) << 2);
            end
            if (!dm_p && $urandom_range(0, 2) == 0) begin
                dm_p = 1; d_we = 1'($urandom_range(0, 1)); d_w = $urandom;
                d_a  = 32'h2000_0000 | (32'($urandom_range(0, 15)) << 2);
            end
            if_req = if_p; if_addr = i_a;
            dm_req = dm_p; dm_we = d_we; dm_addr = d_a; dm_wdata = d_w;
            if (c >= idle_at && (if_p || dm_p)) begin
                if (if_p && dm_p) begin
                    dm_win = !last_dm;
                    if (m_conf < 65535) m_conf++;
                end else begin
                    dm_win = dm_p;
                end
                last_dm   = dm_win;
                exp_en_c  = c + 1;
                exp_ack_c = c + LAT + 2;
                idle_at   = c + LAT + 3;
                exp_we    = dm_win ? d_we : 1'b0;
                exp_a     = dm_win ? d_a : i_a;
                exp_w     = d_w;
                exp_rd    = mmem.exists(exp_a) ? mmem[exp_a] : dflt(exp_a);
                if (exp_we) mmem[exp_a] = exp_w;
            end
        end
        if_req = 0; dm_req = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_if_read();
        test_dm_write();
        test_conflict();
        test_fairness();
        test_reset_mid();
        test_held_req();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
